dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Multi-cycle data memory responder: the target side of the pipeline's load/store port.
- Accepts one word load or store per request and completes it after a fixed, parameterised latency.
- Asserts a stall to the pipeline while the access is in flight.
- Sits in the MEM stage in place of the single-cycle data memory; the EX/MEM latch drives its request side.

Parameters:
DEPTH_WORDS  32  number of 32-bit words in the array; legal word index 0..DEPTH_WORDS-1
LATENCY      4   cycles from request acceptance to response; legal range 1..15

Ports:
clk_i    input   1   clock; all state updates on the rising edge
rst_i    input   1   synchronous, active-high reset
req_i    input   1   access request, sampled only in IDLE
we_i     input   1   1 = store, 0 = load; sampled with req_i
addr_i   input   32  byte address; must be word aligned
data_i   input   32  store data; sampled with req_i
stall_o  output  1   combinational; pipeline must hold while high
ack_o    output  1   registered; one-cycle completion pulse
err_o    output  1   registered; valid only while ack_o=1, high means the access was rejected
data_o   output  32  registered load data

Behaviour:
- States: IDLE, WAIT, RESP. A 4-bit down-counter cnt is used only in WAIT.
- Reset (rst_i=1 at a clock edge):
  - state=IDLE, cnt=0, ack_o=0, err_o=0, data_o=0.
  - Array contents are not cleared.
  - Reset takes priority over all other events, including mid-operation: a pending store is discarded and the array is not written.
- Acceptance:
  - In IDLE, req_i=1 at edge T latches we_i, addr_i and data_i, and computes bad = (addr_i[1:0]!=0) or (addr_i[31:2] >= DEPTH_WORDS).
  - LATENCY=1: next state is RESP.
  - LATENCY>1: next state is WAIT with cnt=LATENCY-2.
- WAIT: cnt decrements each edge; when cnt=0, next state is RESP.
- Completion: on the edge that enters RESP (edge T+LATENCY-1), the following happen together:
  - Good store: array[addr[31:2]] <= latched data. data_o is unchanged.
  - Good load: data_o <= array[addr[31:2]].
  - bad access: no array access; data_o <= 0; err_o <= 1.
  - Good access: err_o <= 0.
  - ack_o <= 1.
- RESP lasts exactly one cycle (the cycle following edge T+LATENCY-1).
  - ack_o=1 and stall_o=0 in this cycle.
  - Next state is always IDLE; req_i in the RESP cycle is ignored.
  - On the following edge ack_o <= 0 and err_o <= 0. data_o holds its value until the next load or error response.
- stall_o = (state==IDLE and req_i) or (state==WAIT). It is 0 during RESP and 0 while in reset.
- Requester rule: hold req_i, we_i, addr_i and data_i stable while stall_o=1. After acceptance the latched copies are used; later input changes do not affect the access.
- Back-to-back: a new request may be asserted in the cycle after RESP and is accepted in IDLE. Maximum throughput is one access per LATENCY+1 cycles.
- Store followed by load to the same word returns the stored data; there is no bypass requirement because accesses are serialised.
- Array is word-addressed with indices 0..DEPTH_WORDS-1; there is no wrap-around, and any index >= DEPTH_WORDS is an error.

Test Plan:
- Reset, then store: LATENCY=4, store data 0xDEADBEEF to addr 0x8 accepted at edge T.
  - stall_o=1 from the request cycle through the cycle before ack.
  - ack_o=1 for exactly one cycle after edge T+3, err_o=0, data_o still 0.
- Load from addr 0x8 immediately after the previous scenario: ack_o after 4 cycles with data_o=0xDEADBEEF; data_o is still 0xDEADBEEF after the next store.
- Misaligned load from addr 0x6: ack_o at the normal latency, err_o=1, data_o=0; array unchanged (later load from 0x4 returns prior contents).
- Out-of-range store to addr 0x80 with DEPTH_WORDS=32: err_o=1 with ack_o; a subsequent load from 0x0 shows no aliasing write.
- Reset mid-store: assert rst_i two cycles after accepting a store of 0x12345678 to 0x10.
  - Outputs return to reset values and stall_o=0.
  - A later load from 0x10 returns the old value.
- LATENCY=1, req_i held high continuously:
  - Accesses alternate accept / RESP, with ack_o high every second cycle.
  - The request asserted during the RESP cycle is not accepted until the following IDLE cycle.

Source files
------------

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Load/store port between the MEM-stage latch and the
//               data memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;
    logic [31:0] data_o;

    modport master (
        output req_i, we_i, addr_i, data_i,
        input  stall_o, ack_o, err_o, data_o
    );

    modport slave (
        input  req_i, we_i, addr_i, data_i,
        output stall_o, ack_o, err_o, data_o
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Multi-cycle word data memory with fixed access latency and
//               a pipeline stall while an access is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 4
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    dmem_responder_if.slave   bus
);

    localparam int          c_idx_w    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_depth    = 32'(DEPTH_WORDS);
    localparam logic [3:0]  c_cnt_init = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam bit          c_single   = (LATENCY == 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q,   cnt_d;
    logic               we_q,    we_d;
    logic               bad_q,   bad_d;
    logic [c_idx_w-1:0] idx_q,   idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ack_q,   ack_d;
    logic               err_q,   err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        mem_array [DEPTH_WORDS];

    logic               w_accept;
    logic               w_in_bad;
    logic               w_complete;
    logic               w_cur_we;
    logic               w_cur_bad;
    logic [c_idx_w-1:0] w_cur_idx;
    logic [31:0]        w_cur_wdata;
    logic               w_mem_we;
    logic               w_stall;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= c_st_idle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_st_idle: begin
                if (bus.req_i) begin
                    if (c_single) begin
                        state_d = c_st_resp;
                    end else begin
                        state_d = c_st_wait;
                        cnt_d   = c_cnt_init;
                    end
                end
            end
            c_st_wait: begin
                if (cnt_q == 4'd0) begin
                    state_d = c_st_resp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            c_st_resp: state_d = c_st_idle;
            default:   state_d = c_st_idle;
        endcase
    end

    // Outputs and datapath
    always_comb begin
        w_accept = (state_q == c_st_idle) && bus.req_i;
        w_in_bad = (bus.addr_i[1:0] != 2'b00) || ({2'b00, bus.addr_i[31:2]} >= c_depth);

        we_d    = w_accept ? bus.we_i                   : we_q;
        bad_d   = w_accept ? w_in_bad                   : bad_q;
        idx_d   = w_accept ? bus.addr_i[c_idx_w+1:2]    : idx_q;
        wdata_d = w_accept ? bus.data_i                 : wdata_q;

        // With single-cycle latency the access completes on the accepting
        // edge, so the live inputs stand in for the latched copies.
        w_cur_we    = (state_q == c_st_idle) ? bus.we_i                : we_q;
        w_cur_bad   = (state_q == c_st_idle) ? w_in_bad                : bad_q;
        w_cur_idx   = (state_q == c_st_idle) ? bus.addr_i[c_idx_w+1:2] : idx_q;
        w_cur_wdata = (state_q == c_st_idle) ? bus.data_i              : wdata_q;

        w_complete = (w_accept && c_single) ||
                     ((state_q == c_st_wait) && (cnt_q == 4'd0));

        ack_d   = w_complete;
        err_d   = w_complete && w_cur_bad;
        rdata_d = rdata_q;
        if (w_complete) begin
            if (w_cur_bad) begin
                rdata_d = 32'd0;
            end else if (!w_cur_we) begin
                rdata_d = mem_array[w_cur_idx];
            end
        end

        w_mem_we = w_complete && w_cur_we && !w_cur_bad && !rst_i;
        w_stall  = !rst_i && (w_accept || (state_q == c_st_wait));
    end

    // Array contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            mem_array[w_cur_idx] <= w_cur_wdata;
        end
    end

    assign bus.stall_o = w_stall;
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.data_o  = rdata_q;

endmodule
`default_nettype wire
